// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle control slice.
//   state_t : 4-bit FSM state encoding
//   OP_*    : opcode constants (IR[31:26])
//   ALUOP_* / SRCB_* / PCSRC_* : datapath select codes
//   ctrl_t  : bundle of every control strobe driven per cycle
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        R_EXEC    = 4'd2,
        R_WB      = 4'd3,
        MEM_ADDR  = 4'd4,
        MEM_READ  = 4'd5,
        MEM_WB    = 4'd6,
        MEM_WRITE = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        TRAP      = 4'd10,
        ADDI_EXEC = 4'd11,
        ADDI_WB   = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_ADDI  = 6'h08;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_ONE     = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and its datapath.
//   master : controller side (receives run/opCode, drives strobes, illegal, instr_done)
//   slave  : datapath side
interface multicycle_control_if;
    logic       run;
    logic [5:0] opCode;
    logic       PCWriteCond;
    logic       PCWrite;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       IRWrite;
    logic [1:0] PCSource;
    logic [1:0] ALUOp;
    logic [1:0] ALUSrcB;
    logic       ALUSrcA;
    logic       RegWrite;
    logic       RegDst;
    logic       illegal;
    logic       instr_done;

    modport master (
        input  run, opCode,
        output PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, illegal, instr_done
    );

    modport slave (
        output run, opCode,
        input  PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
               PCSource, ALUOp, ALUSrcB, ALUSrcA, RegWrite, RegDst, illegal, instr_done
    );
endinterface

// File: rtl/multicycle_control_wait_counter.sv
// mc_wait_counter: 3-bit saturating wait counter for memory read latency.
//   clk, reset (async, active-low)
//   clear : synchronous clear to 0 (takes priority)
//   done  : count has reached LIMIT
module mc_wait_counter #(
    parameter logic [2:0] LIMIT = 3'd1
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic done
);
    logic [2:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (count != LIMIT)
            count <= count + 3'd1;
    end

    assign done = (count == LIMIT);
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM of the multicycle datapath (Moore).
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : multicycle_control_if.master (run, opCode in; all strobes,
//           illegal and instr_done out)
//   MEM_WAIT (0..7): extra cycles MemRead is held before data is consumed.
// Optional: MC_CTRL_ADDI_EN adds the addi (opcode 0x08) sequence;
// without it 0x08 traps as illegal.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    multicycle_control_if.master       bus
);
    localparam logic [2:0] WAIT_LIMIT = 3'(MEM_WAIT);

    state_t state, state_next;
    ctrl_t  ctrl;
    logic   wait_done, wait_clear, illegal_q;

    function automatic state_t decode_op(input logic [5:0] op);
        case (op)
            OP_RTYPE:     return R_EXEC;
            OP_LW, OP_SW: return MEM_ADDR;
            OP_BEQ:       return BRANCH;
            OP_J:         return JUMP;
`ifdef MC_CTRL_ADDI_EN
            OP_ADDI:      return ADDI_EXEC;
`else
            OP_ADDI:      return TRAP;
`endif
            default:      return TRAP;
        endcase
    endfunction

    // Idle FETCH also clears, so a fetch restarts cleanly whenever run rises.
    assign wait_clear = (state_next != state) || (state == FETCH && !bus.run);

    mc_wait_counter #(.LIMIT(WAIT_LIMIT)) u_wait (
        .clk   (clk),
        .reset (reset),
        .clear (wait_clear),
        .done  (wait_done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= FETCH;
            illegal_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next == TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            FETCH:     if (bus.run && wait_done) state_next = DECODE;
            DECODE:    state_next = decode_op(bus.opCode);
            R_EXEC:    state_next = R_WB;
            MEM_ADDR:  state_next = (bus.opCode == OP_SW) ? MEM_WRITE : MEM_READ;
            MEM_READ:  if (wait_done) state_next = MEM_WB;
            TRAP:      state_next = TRAP;
`ifdef MC_CTRL_ADDI_EN
            ADDI_EXEC: state_next = ADDI_WB;
            ADDI_WB:   state_next = FETCH;
`endif
            R_WB, MEM_WB, MEM_WRITE, BRANCH, JUMP: state_next = FETCH;
            default:   state_next = FETCH;
        endcase
    end

    always_comb begin
        ctrl = '0;
        case (state)
            FETCH: begin
                if (bus.run) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b0;
                    if (wait_done) begin
                        ctrl.ir_write  = 1'b1;
                        ctrl.alu_src_a = 1'b0;
                        ctrl.alu_src_b = SRCB_ONE;
                        ctrl.alu_op    = ALUOP_ADD;
                        ctrl.pc_source = PCSRC_ALU;
                        ctrl.pc_write  = 1'b1;
                    end
                end
            end
            DECODE: begin
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SL2;
                ctrl.alu_op    = ALUOP_ADD;
            end
            R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            R_WB: begin
                ctrl.reg_dst    = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            MEM_WRITE: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_B;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.pc_write_cond = 1'b1;
                ctrl.instr_done    = 1'b1;
            end
            JUMP: begin
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.pc_write   = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            ADDI_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ctrl = '0;
        endcase
        // FETCH decodes run directly, so strobes are forced low while reset
        // is held to keep the datapath quiet during the reset window.
        if (!reset)
            ctrl = '0;
    end

    assign bus.PCWriteCond = ctrl.pc_write_cond;
    assign bus.PCWrite     = ctrl.pc_write;
    assign bus.IorD        = ctrl.i_or_d;
    assign bus.MemRead     = ctrl.mem_read;
    assign bus.MemWrite    = ctrl.mem_write;
    assign bus.MemtoReg    = ctrl.mem_to_reg;
    assign bus.IRWrite     = ctrl.ir_write;
    assign bus.PCSource    = ctrl.pc_source;
    assign bus.ALUOp       = ctrl.alu_op;
    assign bus.ALUSrcB     = ctrl.alu_src_b;
    assign bus.ALUSrcA     = ctrl.alu_src_a;
    assign bus.RegWrite    = ctrl.reg_write;
    assign bus.RegDst      = ctrl.reg_dst;
    assign bus.instr_done  = ctrl.instr_done;
    assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Directed testbench for multicycle_control with MEM_WAIT = 1 (k = 2).
// Control word layout compared each cycle:
//   {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
//    PCSource[1:0], ALUOp[1:0], ALUSrcB[1:0], ALUSrcA, RegWrite, RegDst, instr_done}
module tb_multicycle_control;
    logic clk;
    logic reset;

    multicycle_control_if bus();

    multicycle_control #(.MEM_WAIT(1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [16:0] PCWC    = 17'd1 << 16;
    localparam logic [16:0] PCW     = 17'd1 << 15;
    localparam logic [16:0] IORD    = 17'd1 << 14;
    localparam logic [16:0] MR      = 17'd1 << 13;
    localparam logic [16:0] MW      = 17'd1 << 12;
    localparam logic [16:0] M2R     = 17'd1 << 11;
    localparam logic [16:0] IRW     = 17'd1 << 10;
    localparam logic [16:0] PCS_01  = 17'd1 << 8;
    localparam logic [16:0] PCS_10  = 17'd2 << 8;
    localparam logic [16:0] AOP_SUB = 17'd1 << 6;
    localparam logic [16:0] AOP_FN  = 17'd2 << 6;
    localparam logic [16:0] SB_1    = 17'd1 << 4;
    localparam logic [16:0] SB_IMM  = 17'd2 << 4;
    localparam logic [16:0] SB_IMM4 = 17'd3 << 4;
    localparam logic [16:0] SA      = 17'd1 << 3;
    localparam logic [16:0] RW      = 17'd1 << 2;
    localparam logic [16:0] RD      = 17'd1 << 1;
    localparam logic [16:0] DONE    = 17'd1;

    localparam logic [16:0] F1   = MR;
    localparam logic [16:0] F2   = MR | IRW | PCW | SB_1;
    localparam logic [16:0] DEC  = SB_IMM4;
    localparam logic [16:0] IDLE = 17'd0;

    int n_cmp = 0;
    int n_bad = 0;
    logic [16:0] exp_seq [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] cw();
        return {bus.PCWriteCond, bus.PCWrite, bus.IorD, bus.MemRead, bus.MemWrite,
                bus.MemtoReg, bus.IRWrite, bus.PCSource, bus.ALUOp, bus.ALUSrcB,
                bus.ALUSrcA, bus.RegWrite, bus.RegDst, bus.instr_done};
    endfunction

    // Called just after a falling edge with the FSM in FETCH; checks n
    // consecutive cycles against exp_seq, leaves run low on a falling edge.
    task automatic exec(input string tag, input logic [5:0] opc, input int n);
        bus.opCode = opc;
        bus.run    = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            #1 check($sformatf("%s[%0d]", tag, i), 32'(cw()), 32'(exp_seq[i]));
        end
        @(negedge clk);
        bus.run = 1'b0;
    endtask

    task automatic reset_pulse();
        reset = 1'b0;
        #1 check("rst_illegal", 32'(bus.illegal), 32'd0);
        check("rst_strobes", 32'(cw()), 32'(IDLE));
        @(negedge clk);
        reset   = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset      = 1'b0;
        bus.run    = 1'b1;
        bus.opCode = 6'h00;

        // Reset state, with run high to show the strobes stay quiet.
        @(negedge clk);
        #1 check("reset_strobes", 32'(cw()), 32'(IDLE));
        check("reset_illegal", 32'(bus.illegal), 32'd0);
        reset   = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("idle_fetch", 32'(cw()), 32'(IDLE));
        @(negedge clk);

        // R-type: k + 3 = 5 cycles.
        exp_seq = '{F1, F2, DEC, SA | AOP_FN, RD | RW | DONE, IDLE, IDLE, IDLE};
        exec("rtype", 6'h00, 5);
        #1 check("idle_after_r", 32'(cw()), 32'(IDLE));
        check("r_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);

        // lw: 2k + 3 = 7 cycles.
        exp_seq = '{F1, F2, DEC, SA | SB_IMM, MR | IORD, MR | IORD, M2R | RW | DONE, IDLE};
        exec("lw", 6'h23, 7);

        // sw: k + 3 = 5 cycles.
        exp_seq = '{F1, F2, DEC, SA | SB_IMM, MW | IORD | DONE, IDLE, IDLE, IDLE};
        exec("sw", 6'h2B, 5);

        // beq: k + 2 = 4 cycles.
        exp_seq = '{F1, F2, DEC, SA | AOP_SUB | PCS_01 | PCWC | DONE, IDLE, IDLE, IDLE, IDLE};
        exec("beq", 6'h04, 4);

        // j: k + 2 = 4 cycles.
        exp_seq = '{F1, F2, DEC, PCS_10 | PCW | DONE, IDLE, IDLE, IDLE, IDLE};
        exec("j", 6'h02, 4);

        // Reset asserted during the first MEM_READ cycle of a lw.
        exp_seq = '{F1, F2, DEC, SA | SB_IMM, MR | IORD, IDLE, IDLE, IDLE};
        bus.opCode = 6'h23;
        bus.run    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            #1 check($sformatf("lw_cut[%0d]", i), 32'(cw()), 32'(exp_seq[i]));
        end
        reset = 1'b0;
        #1 check("cut_strobes", 32'(cw()), 32'(IDLE));
        @(negedge clk);
        #1 check("cut_held", 32'(cw()), 32'(IDLE));
        reset   = 1'b1;
        bus.run = 1'b0;
        @(negedge clk);
        #1 check("cut_idle", 32'(cw()), 32'(IDLE));
        check("cut_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        exp_seq = '{F1, F2, DEC, SA | AOP_FN, RD | RW | DONE, IDLE, IDLE, IDLE};
        exec("r_after_cut", 6'h00, 5);

        // addi: executes with the option enabled, traps otherwise.
`ifdef MC_CTRL_ADDI_EN
        exp_seq = '{F1, F2, DEC, SA | SB_IMM, RW | DONE, IDLE, IDLE, IDLE};
        exec("addi", 6'h08, 5);
        #1 check("addi_illegal", 32'(bus.illegal), 32'd0);
`else
        exp_seq = '{F1, F2, DEC, IDLE, IDLE, IDLE, IDLE, IDLE};
        exec("addi_trap", 6'h08, 4);
        #1 check("addi_illegal", 32'(bus.illegal), 32'd1);
`endif
        @(negedge clk);
        reset_pulse();

        // Undefined opcode: illegal only after DECODE, trap ignores run.
        exp_seq = '{F1, F2, DEC, IDLE, IDLE, IDLE, IDLE, IDLE};
        bus.opCode = 6'h3F;
        bus.run    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            #1 check($sformatf("trap_pre[%0d]", i), 32'(cw()), 32'(exp_seq[i]));
        end
        check("decode_illegal", 32'(bus.illegal), 32'd0);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            #1 check($sformatf("trap_hold[%0d]", i), 32'(cw()), 32'(IDLE));
            check($sformatf("trap_illegal[%0d]", i), 32'(bus.illegal), 32'd1);
            @(negedge clk);
        end
        reset_pulse();

        exp_seq = '{F1, F2, DEC, PCS_10 | PCW | DONE, IDLE, IDLE, IDLE, IDLE};
        exec("j_after_trap", 6'h02, 4);
        #1 check("final_illegal", 32'(bus.illegal), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
